instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Synthesizable instruction-fetch front end for the 16-bit accumulator CPU.
- Replaces the bench-driven fetch sequence (MAR<=PC, IR<=data, PC+=2).
- Reads instruction words from single_port_sync_ram_large and hands them to the decode/execute stage with a valid/ready handshake.
- Accepts redirects (jump/skip) and a halt request from execute.
- Shares the single RAM port with execute via a grant input.

Parameters:
- ADDR_WIDTH, 14: width of PC and RAM address.
- DATA_WIDTH, 16: instruction word width.
- RESET_PC, 'h100: PC value after reset.
- PC_STEP, 2: PC increment per fetched instruction.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- bus_gnt  in  1  1 = fetch may drive the RAM port this cycle.
- mem_addr  out  ADDR_WIDTH  RAM address (MAR).
- mem_cs  out  1  RAM chip select.
- mem_we  out  1  RAM write enable; constant 0.
- mem_oe  out  1  RAM output enable (1 = RAM drives data).
- mem_rdata  in  DATA_WIDTH  RAM read data, valid one cycle after the address is presented.
- ir  out  DATA_WIDTH  fetched instruction.
- ir_pc  out  ADDR_WIDTH  address the instruction was fetched from.
- ir_valid  out  1  ir/ir_pc hold a valid instruction.
- ir_ready  in  1  execute accepts ir this cycle.
- redirect  in  1  load PC from redirect_pc and flush.
- redirect_pc  in  ADDR_WIDTH  new PC; bit 0 forced to 0.
- halt  in  1  stop fetching permanently until reset.
- halted  out  1  fetch unit is in HALTED.
- pc  out  ADDR_WIDTH  current fetch PC (debug).

Behaviour:
- Reset (rst_n=0 at an edge, from any state, including mid-read):
  - state=ADDR, pc=RESET_PC, ir=0, ir_pc=0, ir_valid=0, halted=0.
  - mem_cs=0, mem_oe=0, mem_we=0, mem_addr=RESET_PC.
- States:
  - ADDR: if bus_gnt=1, drive mem_addr=pc, mem_cs=1, mem_oe=1 (combinational from state), next state DATA. If bus_gnt=0, mem_cs=mem_oe=0 and stay in ADDR.
  - DATA: mem_cs=mem_oe=0. At the edge: ir<=mem_rdata, ir_pc<=pc, pc<=pc+PC_STEP, ir_valid<=1, next state HOLD. bus_gnt is ignored in DATA; execute must not take the port in this cycle.
  - HOLD: ir_valid=1, ir/ir_pc stable. If ir_ready=1: ir_valid<=0 and next state ADDR. Otherwise stay in HOLD.
  - HALTED: ir_valid=0, mem_cs=mem_oe=0, halted=1. Only reset exits.
- Latency: grant in ADDR at cycle N -> ir_valid=1 from cycle N+2. Minimum 3 cycles per instruction (ADDR, DATA, HOLD with ready).
- Redirect (any state except HALTED):
  - At the edge: pc<={redirect_pc[ADDR_WIDTH-1:1],1'b0}, ir_valid<=0, next state ADDR.
  - Any in-flight DATA capture is discarded; ir/ir_pc keep their old values but are invalid.
  - ir_ready in the same cycle is ignored: no transfer occurs.
- Halt: priority over redirect and ir_ready. At the edge: state<=HALTED, ir_valid<=0. pc is held.
- Priority per edge: reset > halt > redirect > normal FSM.
- Arithmetic: pc+PC_STEP is computed modulo 2^ADDR_WIDTH. Fetch from the top word wraps to 0 with no flag.
- mem_addr holds its last value when mem_cs=0.
- mem_we is never asserted.

Test Plan:
- Reset then sequential fetch: RAM 'h100='h2128, 'h102='h312A, bus_gnt=1, ir_ready=1 -> ir_valid rises 2 cycles after the first ADDR. Transfer 1: ir='h2128, ir_pc='h100. Transfer 2: ir='h312A, ir_pc='h102. Third fetch starts with mem_addr='h104.
- Backpressure: ir_ready=0 for 5 cycles after ir_valid -> ir='h2128 and ir_pc='h100 stable, no mem_cs pulse, pc='h102. Release ready -> next ADDR at 'h102.
- Bus contention: bus_gnt=0 for 4 cycles in ADDR -> mem_cs=0 throughout, state holds. Raise bus_gnt -> fetch proceeds with the correct data.
- Redirect: in HOLD with ir='h6108, assert redirect=1, redirect_pc='h109, ir_ready=1 -> no transfer, ir_valid=0 next cycle, next fetch mem_addr='h108. Also redirect during DATA -> captured word dropped.
- Halt and reset: halt=1 while redirect=1 -> halted=1, ir_valid=0, no further mem_cs, redirect ignored. rst_n=0 for 1 cycle mid-DATA -> pc='h100, halted=0, ir_valid=0.
- Wrap: redirect_pc='h3FFE, fetch one word -> ir_pc='h3FFE, next mem_addr='h0000.

Source files
------------

// File: rtl/instr_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit_if
// Purpose  : Bundles the fetch unit's RAM-port signals, the instruction
//            handshake towards decode/execute, and the execute-side control
//            inputs (redirect, halt).
// Ports    : master modport - fetch unit side (drives RAM address/strobes,
//                             instruction register, status)
//            slave modport  - environment side (RAM, arbiter, execute stage)
// Revision : 1.0 - initial release
// ============================================================================
interface instr_fetch_unit_if #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 16
);
    // RAM port and arbitration
    logic                  bus_gnt;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_cs;
    logic                  mem_we;
    logic                  mem_oe;
    logic [DATA_WIDTH-1:0] mem_rdata;

    // Instruction handshake towards execute
    logic [DATA_WIDTH-1:0] ir;
    logic [ADDR_WIDTH-1:0] ir_pc;
    logic                  ir_valid;
    logic                  ir_ready;

    // Control from execute, status back
    logic                  redirect;
    logic [ADDR_WIDTH-1:0] redirect_pc;
    logic                  halt;
    logic                  halted;
    logic [ADDR_WIDTH-1:0] pc;

    modport master (
        input  bus_gnt, mem_rdata, ir_ready, redirect, redirect_pc, halt,
        output mem_addr, mem_cs, mem_we, mem_oe, ir, ir_pc, ir_valid, halted, pc
    );

    modport slave (
        output bus_gnt, mem_rdata, ir_ready, redirect, redirect_pc, halt,
        input  mem_addr, mem_cs, mem_we, mem_oe, ir, ir_pc, ir_valid, halted, pc
    );
endinterface
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Purpose  : Instruction-fetch front end for the 16-bit accumulator CPU.
//            Reads instruction words from a synchronous single-port RAM
//            (shared with execute through bus_gnt) and presents them to the
//            execute stage with a valid/ready handshake. Supports PC
//            redirects and a sticky halt.
// Ports    : clk   - system clock, rising-edge active
//            rst_n - synchronous active-low reset
//            bus   - instr_fetch_unit_if.master (RAM port, ir handshake,
//                    redirect/halt control, halted/pc status)
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
    parameter int                    ADDR_WIDTH = 14,
    parameter int                    DATA_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 'h100,
    parameter int                    PC_STEP    = 2
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    instr_fetch_unit_if.master     bus
);

    localparam logic [ADDR_WIDTH-1:0] C_PC_STEP = ADDR_WIDTH'(PC_STEP);

    typedef enum logic [1:0] {
        ST_ADDR   = 2'd0,
        ST_DATA   = 2'd1,
        ST_HOLD   = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    state_t                state_q,    state_d;
    logic [ADDR_WIDTH-1:0] pc_q,       pc_d;
    logic [DATA_WIDTH-1:0] ir_q,       ir_d;
    logic [ADDR_WIDTH-1:0] ir_pc_q,    ir_pc_d;
    logic                  ir_valid_q, ir_valid_d;
    logic                  halted_q,   halted_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;

    // A read is issued in any ADDR cycle that owns the port. The strobe is
    // not qualified by redirect/halt: a read issued in the same cycle as a
    // redirect is harmless because its data is never captured.
    logic w_issue;
    assign w_issue = (state_q == ST_ADDR) && bus.bus_gnt;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        ir_pc_d    = ir_pc_q;
        ir_valid_d = ir_valid_q;
        halted_d   = halted_q;
        // The address register remembers the last presented address so the
        // RAM address bus stays quiet while the chip select is low.
        mem_addr_d = w_issue ? pc_q : mem_addr_q;

        unique case (state_q)
            ST_ADDR: begin
                if (bus.bus_gnt) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                // RAM data for the address presented last cycle is on
                // mem_rdata now.
                ir_d       = bus.mem_rdata;
                ir_pc_d    = pc_q;
                pc_d       = pc_q + C_PC_STEP;
                ir_valid_d = 1'b1;
                state_d    = ST_HOLD;
            end
            ST_HOLD: begin
                if (bus.ir_ready) begin
                    ir_valid_d = 1'b0;
                    state_d    = ST_ADDR;
                end
            end
            ST_HALTED: begin
                ir_valid_d = 1'b0;
            end
            default: begin
                state_d = ST_ADDR;
            end
        endcase

        // Redirect overrides the normal step: any capture in progress is
        // dropped, the old ir/ir_pc stay but are marked invalid, and a
        // simultaneous ir_ready does not count as a transfer.
        if (bus.redirect && (state_q != ST_HALTED)) begin
            pc_d       = {bus.redirect_pc[ADDR_WIDTH-1:1], 1'b0};
            ir_d       = ir_q;
            ir_pc_d    = ir_pc_q;
            ir_valid_d = 1'b0;
            state_d    = ST_ADDR;
        end

        // Halt wins over redirect and ready; pc freezes where it is.
        if (bus.halt) begin
            pc_d       = pc_q;
            ir_d       = ir_q;
            ir_pc_d    = ir_pc_q;
            ir_valid_d = 1'b0;
            halted_d   = 1'b1;
            state_d    = ST_HALTED;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_ADDR;
            pc_q       <= RESET_PC;
            ir_q       <= '0;
            ir_pc_q    <= '0;
            ir_valid_q <= 1'b0;
            halted_q   <= 1'b0;
            mem_addr_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ir_pc_q    <= ir_pc_d;
            ir_valid_q <= ir_valid_d;
            halted_q   <= halted_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    assign bus.mem_addr = w_issue ? pc_q : mem_addr_q;
    assign bus.mem_cs   = w_issue;
    assign bus.mem_oe   = w_issue;
    assign bus.mem_we   = 1'b0;
    assign bus.ir       = ir_q;
    assign bus.ir_pc    = ir_pc_q;
    assign bus.ir_valid = ir_valid_q;
    assign bus.halted   = halted_q;
    assign bus.pc       = pc_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch_unit
// Purpose  : Self-checking bench for instr_fetch_unit. A RAM model serves
//            reads; a transaction-level reference (next instruction address,
//            halted flag, last presented RAM address) predicts every
//            delivered instruction and the bus behaviour. Directed steps are
//            followed by a randomized phase.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

    localparam int              AW       = 14;
    localparam int              DW       = 16;
    localparam logic [AW-1:0]   RESET_PC = 14'h100;

    logic clk;
    logic rst_n;

    instr_fetch_unit_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    instr_fetch_unit #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .RESET_PC   (RESET_PC),
        .PC_STEP    (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM: data appears one cycle after the address.
    logic [DW-1:0] ram [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (bus.mem_cs && !bus.mem_we) begin
            bus.mem_rdata <= ram[bus.mem_addr];
        end
    end

    int checks = 0;
    int errors = 0;

    // Reference state
    logic [AW-1:0] m_pc;        // address of the next instruction to deliver
    logic          m_halted;
    logic [AW-1:0] held_addr;   // last address presented to the RAM
    logic          last_clear;  // previous edge must have dropped ir_valid
    logic          last_hold;   // previous edge must have kept ir stable
    logic [DW-1:0] prev_ir;
    logic [AW-1:0] prev_ir_pc;
    int            transfers;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle. Inputs are set by the caller while clk is low.
    task automatic tick();
        int            ev;   // 0 none, 1 reset, 2 halt, 3 redirect, 4 transfer
        logic          cs_s;
        logic          v_s;
        logic          rdy_s;
        logic [DW-1:0] ir_s;
        logic [AW-1:0] irpc_s;
        logic [AW-1:0] rpc_s;
        #1;
        check("mem_we_low", {31'd0, bus.mem_we}, 32'd0);
        check("cs_needs_gnt", {31'd0, bus.mem_cs & ~bus.bus_gnt}, 32'd0);
        check("oe_needs_gnt", {31'd0, bus.mem_oe & ~bus.bus_gnt}, 32'd0);
        check("mem_addr", {18'd0, bus.mem_addr}, {18'd0, (bus.mem_cs ? m_pc : held_addr)});
        check("halted", {31'd0, bus.halted}, {31'd0, m_halted});
        if (m_halted) begin
            check("halt_no_cs", {31'd0, bus.mem_cs}, 32'd0);
            check("halt_no_valid", {31'd0, bus.ir_valid}, 32'd0);
        end
        if (last_clear) check("valid_dropped", {31'd0, bus.ir_valid}, 32'd0);
        if (last_hold) begin
            check("hold_valid", {31'd0, bus.ir_valid}, 32'd1);
            check("hold_ir", {16'd0, bus.ir}, {16'd0, prev_ir});
            check("hold_ir_pc", {18'd0, bus.ir_pc}, {18'd0, prev_ir_pc});
        end
        if (bus.ir_valid && !m_halted) begin
            check("ir_pc_model", {18'd0, bus.ir_pc}, {18'd0, m_pc});
            check("ir_model", {16'd0, bus.ir}, {16'd0, ram[m_pc]});
        end
        cs_s   = bus.mem_cs;
        v_s    = bus.ir_valid;
        rdy_s  = bus.ir_ready;
        ir_s   = bus.ir;
        irpc_s = bus.ir_pc;
        rpc_s  = bus.redirect_pc;
        if (!rst_n)                          ev = 1;
        else if (bus.halt)                   ev = 2;
        else if (bus.redirect && !m_halted)  ev = 3;
        else if (v_s && rdy_s)               ev = 4;
        else                                 ev = 0;
        @(posedge clk);
        if (ev == 1) begin
            m_pc      = RESET_PC;
            m_halted  = 1'b0;
            held_addr = RESET_PC;
        end else begin
            if (cs_s) held_addr = m_pc;
            case (ev)
                2: m_halted = 1'b1;
                3: m_pc = {rpc_s[AW-1:1], 1'b0};
                4: begin
                    m_pc = m_pc + 14'd2;
                    transfers++;
                end
                default: ;
            endcase
        end
        last_clear = (ev != 0);
        last_hold  = (ev == 0) && v_s && !rdy_s && !m_halted;
        prev_ir    = ir_s;
        prev_ir_pc = irpc_s;
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) ram[i] = 16'($urandom);
        ram[14'h100]  = 16'h2128;
        ram[14'h102]  = 16'h312A;
        ram[14'h104]  = 16'h6108;
        ram[14'h3FFE] = 16'hA5A5;

        m_pc = RESET_PC; m_halted = 1'b0; held_addr = RESET_PC;
        last_clear = 1'b0; last_hold = 1'b0; prev_ir = '0; prev_ir_pc = '0;
        transfers = 0;

        rst_n = 1'b0;
        bus.bus_gnt = 1'b0; bus.ir_ready = 1'b0; bus.redirect = 1'b0;
        bus.redirect_pc = '0; bus.halt = 1'b0; bus.mem_rdata = '0;
        @(negedge clk);
        tick(); tick();

        // Reset state
        rst_n = 1'b1;
        #1;
        check("rst_pc", {18'd0, bus.pc}, 32'h100);
        check("rst_ir", {16'd0, bus.ir}, 32'h0);
        check("rst_ir_pc", {18'd0, bus.ir_pc}, 32'h0);
        check("rst_valid", {31'd0, bus.ir_valid}, 32'd0);
        check("rst_cs", {31'd0, bus.mem_cs}, 32'd0);
        check("rst_mem_addr", {18'd0, bus.mem_addr}, 32'h100);

        // Sequential fetch and latency
        bus.bus_gnt = 1'b1; bus.ir_ready = 1'b1;
        #1;
        check("seq_cs0", {31'd0, bus.mem_cs}, 32'd1);
        check("seq_addr0", {18'd0, bus.mem_addr}, 32'h100);
        tick();
        check("seq_lat_n1", {31'd0, bus.ir_valid}, 32'd0);
        tick();
        check("seq_lat_n2", {31'd0, bus.ir_valid}, 32'd1);
        check("seq_ir0", {16'd0, bus.ir}, 32'h2128);
        check("seq_ir_pc0", {18'd0, bus.ir_pc}, 32'h100);
        tick(); tick(); tick();
        check("seq_ir1", {16'd0, bus.ir}, 32'h312A);
        check("seq_ir_pc1", {18'd0, bus.ir_pc}, 32'h102);
        tick();
        check("seq_addr2", {18'd0, bus.mem_addr}, 32'h104);
        check("seq_cs2", {31'd0, bus.mem_cs}, 32'd1);

        // Backpressure: refetch 0x100 and hold it
        bus.redirect = 1'b1; bus.redirect_pc = 14'h100;
        tick();
        bus.redirect = 1'b0; bus.ir_ready = 1'b0;
        tick(); tick();
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_ir", {16'd0, bus.ir}, 32'h2128);
            check("bp_cs", {31'd0, bus.mem_cs}, 32'd0);
            check("bp_pc", {18'd0, bus.pc}, 32'h102);
            tick();
        end
        bus.ir_ready = 1'b1;
        tick();
        check("bp_next_addr", {18'd0, bus.mem_addr}, 32'h102);

        // Bus contention
        bus.bus_gnt = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("gnt_cs_low", {31'd0, bus.mem_cs}, 32'd0);
            tick();
        end
        bus.bus_gnt = 1'b1;
        #1;
        check("gnt_addr", {18'd0, bus.mem_addr}, 32'h102);
        tick(); tick();
        check("gnt_ir", {16'd0, bus.ir}, 32'h312A);
        tick();

        // Redirect in HOLD with simultaneous ready
        bus.ir_ready = 1'b0;
        tick(); tick();
        check("redir_hold_ir", {16'd0, bus.ir}, 32'h6108);
        bus.redirect = 1'b1; bus.redirect_pc = 14'h109; bus.ir_ready = 1'b1;
        tick();
        bus.redirect = 1'b0; bus.ir_ready = 1'b0;
        #1;
        check("redir_valid", {31'd0, bus.ir_valid}, 32'd0);
        check("redir_pc", {18'd0, bus.pc}, 32'h108);
        check("redir_addr", {18'd0, bus.mem_addr}, 32'h108);
        check("redir_ir_kept", {16'd0, bus.ir}, 32'h6108);
        tick();
        // Redirect during DATA: captured word dropped
        bus.redirect = 1'b1; bus.redirect_pc = 14'h200;
        tick();
        bus.redirect = 1'b0;
        #1;
        check("redir_data_valid", {31'd0, bus.ir_valid}, 32'd0);
        check("redir_data_pc", {18'd0, bus.pc}, 32'h200);
        tick(); tick();
        check("redir_data_ir_pc", {18'd0, bus.ir_pc}, 32'h200);
        bus.ir_ready = 1'b1;
        tick();

        // Halt beats redirect
        bus.halt = 1'b1; bus.redirect = 1'b1; bus.redirect_pc = 14'h300;
        tick();
        bus.halt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("halt_flag", {31'd0, bus.halted}, 32'd1);
            check("halt_pc", {18'd0, bus.pc}, 32'h202);
            tick();
        end
        bus.redirect = 1'b0;

        // Reset exits halt, then reset mid-DATA
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; bus.bus_gnt = 1'b0;
        #1;
        check("rst_data_pc", {18'd0, bus.pc}, 32'h100);
        check("rst_data_halted", {31'd0, bus.halted}, 32'd0);
        check("rst_data_valid", {31'd0, bus.ir_valid}, 32'd0);

        // Wrap at top of memory (bit 0 of redirect target forced low)
        bus.redirect = 1'b1; bus.redirect_pc = 14'h3FFF;
        tick();
        bus.redirect = 1'b0; bus.bus_gnt = 1'b1; bus.ir_ready = 1'b1;
        #1;
        check("wrap_addr", {18'd0, bus.mem_addr}, 32'h3FFE);
        tick(); tick();
        check("wrap_ir_pc", {18'd0, bus.ir_pc}, 32'h3FFE);
        check("wrap_ir", {16'd0, bus.ir}, 32'hA5A5);
        tick();
        check("wrap_pc", {18'd0, bus.pc}, 32'h0);
        check("wrap_next_addr", {18'd0, bus.mem_addr}, 32'h0);

        // Randomized phase
        transfers = 0;
        for (int i = 0; i < 3000; i++) begin
            rst_n           = ($urandom_range(0, 199) != 0);
            bus.bus_gnt     = ($urandom_range(0, 9) < 7);
            bus.ir_ready    = ($urandom_range(0, 9) < 6);
            bus.redirect    = ($urandom_range(0, 19) == 0);
            bus.redirect_pc = 14'($urandom_range(0, (1 << AW) - 1));
            bus.halt        = ($urandom_range(0, 299) == 0);
            if (m_halted && $urandom_range(0, 49) == 0) rst_n = 1'b0;
            tick();
        end
        check("random_progress", {31'd0, (transfers > 100)}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
